// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub accumulator stage.
// A reference helper is included for models that need a golden result.
package addsub_pkg;

    localparam int ADDSUB_W_DEFAULT = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_e;

    // Result MSB is the carry for add and the borrow for sub (modulo 2^(W+1)).
    function automatic logic [ADDSUB_W_DEFAULT:0] addsub_ref(
        input logic [ADDSUB_W_DEFAULT-1:0] a,
        input logic [ADDSUB_W_DEFAULT-1:0] b,
        input logic                        sub
    );
        return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

endpackage

// File: rtl/addsub_rca_core.sv
// Combinational WIDTH-bit ripple-carry adder/subtractor.
// s[WIDTH] is the carry out on add and the borrow (a < b) on sub.
module addsub_rca_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   s
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;

    assign bx   = b ^ {WIDTH{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    // Two's-complement subtract leaves carry=1 when no borrow occurred.
    assign s[WIDTH] = c[WIDTH] ^ sub;

endmodule

// File: rtl/addsub_acc_stage.sv
// Registered add/sub stage with valid/ready handshake, accumulator and sticky carry/borrow flag.
// Optional ADDSUB_OP_COUNT_EN adds a 16-bit accepted-operation counter output.
module addsub_acc_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_acc,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_res,
    output logic [WIDTH-1:0] acc_q,
    output logic             ovf_sticky
`ifdef ADDSUB_OP_COUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    buf_e             state;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH:0]   res;
    op_e              op;

    assign out_valid = (state == BUF_FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign op        = op_e'(in_sub);

    // A clear in the same cycle makes an accumulate see zero, not the stale value.
    assign a_sel = in_acc ? (acc_clear ? '0 : acc_q) : in_a;

    addsub_rca_core #(.WIDTH(WIDTH)) u_core (
        .a   (a_sel),
        .b   (in_b),
        .sub (op == OP_SUB),
        .s   (res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BUF_EMPTY;
            out_res    <= '0;
            acc_q      <= '0;
            ovf_sticky <= 1'b0;
        end else if (accept) begin
            state      <= BUF_FULL;
            out_res    <= res;
            acc_q      <= res[WIDTH-1:0];
            ovf_sticky <= acc_clear ? res[WIDTH] : (ovf_sticky | res[WIDTH]);
        end else begin
            if (drain)
                state <= BUF_EMPTY;
            if (acc_clear) begin
                acc_q      <= '0;
                ovf_sticky <= 1'b0;
            end
        end
    end

`ifdef ADDSUB_OP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (accept)
            op_count <= acc_clear ? 16'd1 : op_count + 16'd1;
        else if (acc_clear)
            op_count <= '0;
    end
`endif

endmodule

// File: tb/tb_addsub_acc_stage.sv
// Self-checking bench for addsub_acc_stage: directed vector table, hand sequences,
// and randomized traffic against an integer-arithmetic reference model.
module tb_addsub_acc_stage;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_acc;
    logic         acc_clear;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_res;
    logic [W-1:0] acc_q;
    logic         ovf_sticky;
`ifdef ADDSUB_OP_COUNT_EN
    logic [15:0]  op_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_acc_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_acc     (in_acc),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .acc_q      (acc_q),
        .ovf_sticky (ovf_sticky)
`ifdef ADDSUB_OP_COUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    typedef struct {
        int v, a, b, sub, acc, clr, ordy;
        int e_valid, e_res, e_acc, e_sticky;
    } vec_t;

    vec_t vecs[10];

    // Reference model state
    int m_valid, m_res, m_acc, m_sticky;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int a, input int b, input int sub,
                         input int acc, input int clr, input int ordy);
        in_valid  = v[0];
        in_a      = a[W-1:0];
        in_b      = b[W-1:0];
        in_sub    = sub[0];
        in_acc    = acc[0];
        acc_clear = clr[0];
        out_ready = ordy[0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        rst = 1'b0;
        m_valid = 0; m_res = 0; m_acc = 0; m_sticky = 0;
    endtask

    // Model one clock edge with the currently driven inputs.
    task automatic model_edge();
        int av, r;
        bit acc_ok;
        acc_ok = in_valid && (m_valid == 0 || out_ready);
        if (acc_ok) begin
            av = in_acc ? (acc_clear ? 0 : m_acc) : int'(in_a);
            r  = in_sub ? (av - int'(in_b) + 32) % 32 : av + int'(in_b);
            m_res    = r;
            m_valid  = 1;
            m_acc    = r % 16;
            m_sticky = acc_clear ? (r >= 16) : (m_sticky | int'(r >= 16));
        end else begin
            if (m_valid != 0 && out_ready) m_valid = 0;
            if (acc_clear) begin
                m_acc = 0;
                m_sticky = 0;
            end
        end
    endtask

    initial begin
        //           v  a   b  sub acc clr rdy  valid res acc sticky
        vecs[0] = '{1, 9,  8, 0,  0,  0,  1,   1, 17,  1, 1};
        vecs[1] = '{0, 0,  0, 0,  0,  1,  1,   0,  0,  0, 0};
        vecs[2] = '{1, 3,  5, 1,  0,  0,  1,   1, 30, 14, 1};
        vecs[3] = '{1, 5,  3, 1,  0,  0,  1,   1,  2,  2, 1};
        vecs[4] = '{0, 0,  0, 0,  0,  1,  1,   0,  0,  0, 0};
        vecs[5] = '{1, 0,  3, 0,  1,  0,  1,   1,  3,  3, 0};
        vecs[6] = '{1, 0,  3, 0,  1,  0,  1,   1,  6,  6, 0};
        vecs[7] = '{1, 0,  3, 0,  1,  0,  1,   1,  9,  9, 0};
        vecs[8] = '{1, 15, 8, 0,  0,  0,  1,   1, 23,  7, 1};
        vecs[9] = '{1, 0,  2, 0,  1,  1,  1,   1,  2,  2, 0};

        do_reset();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_res", out_res, 0);
        chk("reset acc_q", acc_q, 0);
        chk("reset ovf_sticky", ovf_sticky, 0);
        chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].acc, vecs[i].clr, vecs[i].ordy);
            tick();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid != 0)
                chk($sformatf("vec%0d out_res", i), out_res, vecs[i].e_res);
            chk($sformatf("vec%0d acc_q", i), acc_q, vecs[i].e_acc);
            chk($sformatf("vec%0d ovf_sticky", i), ovf_sticky, vecs[i].e_sticky);
        end

        // Backpressure: result must hold and new requests stall until drain.
        do_reset();
        drive(1, 2, 2, 0, 0, 0, 0);
        tick();
        chk("bp first out_res", out_res, 4);
        drive(1, 7, 1, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            chk("bp in_ready low", in_ready, 0);
            tick();
            chk("bp out_valid held", out_valid, 1);
            chk("bp out_res held", out_res, 4);
            chk("bp acc_q held", acc_q, 4);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready via out_ready", in_ready, 1);
        tick();
        chk("bp drain-accept out_valid", out_valid, 1);
        chk("bp drain-accept out_res", out_res, 8);
        chk("bp drain-accept acc_q", acc_q, 8);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("bp final drain", out_valid, 0);

        // Reset while a result is pending clears state immediately.
        drive(1, 15, 15, 0, 0, 0, 0);
        tick();
        chk("rst pre out_valid", out_valid, 1);
        chk("rst pre ovf_sticky", ovf_sticky, 1);
        rst = 1'b1;
        #1;
        chk("rst async out_valid", out_valid, 0);
        chk("rst async acc_q", acc_q, 0);
        chk("rst async ovf_sticky", ovf_sticky, 0);
        chk("rst async out_res", out_res, 0);
        #1;
        rst = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 2) != 0));
            #1;
            chk("rnd in_ready", in_ready, (m_valid == 0 || out_ready) ? 1 : 0);
            model_edge();
            tick();
            chk("rnd out_valid", out_valid, m_valid);
            if (m_valid != 0) chk("rnd out_res", out_res, m_res);
            chk("rnd acc_q", acc_q, m_acc);
            chk("rnd ovf_sticky", ovf_sticky, m_sticky);
        end

`ifdef ADDSUB_OP_COUNT_EN
        do_reset();
        chk("opcnt reset", op_count, 0);
        drive(1, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 65537; i++) tick();
        chk("opcnt wrap", op_count, 1);
        drive(1, 1, 1, 0, 0, 1, 1);
        tick();
        chk("opcnt clear with accept", op_count, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("opcnt clear", op_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
